rv32_instr_encoder: RTL and testbench
=====================================

Name: rv32_instr_encoder

Overview:
- Field-level RV32I instruction encoder and instruction-memory loader. It is the inverse of the control unit: the control unit decodes opcode[6:2] into controls; this block packs opcode selector, register and immediate fields into 32-bit words.
- Accepts one instruction request per valid/ready handshake, encodes it, and writes it to sequential instruction-memory addresses starting at 0.
- Holds the core in reset while loading.

Parameters:
- DEPTH, 64, number of instruction-memory words to fill.
- ADDR_W, 6, address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_last  in  1  marks the final instruction of the program.
- sel  in  5  opcode[6:2] (same encoding the control unit decodes).
- funct3  in  3  funct3 field.
- funct7b5  in  1  instr[30] for R-type and shift-immediate.
- rd, rs1, rs2  in  5 each  register fields.
- imm  in  32  signed byte immediate; for U-type, the full 32-bit value.
- restart  in  1  single-cycle pulse; starts a new load.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- done  out  1  load complete.
- cpu_hold  out  1  high while state is not DONE.
- err_unsup  out  1  sticky: unsupported selector seen.
- err_imm  out  1  sticky: immediate out of range or misaligned.

Behaviour:
- Reset values: state=LOAD, mem_addr=0, mem_we=0, mem_wdata=0, done=0, cpu_hold=1, err_unsup=0, err_imm=0, in_ready=1.
- Reset mid-write aborts that write; no mem_we is issued on the reset cycle.
- FSM has three states: LOAD, WRITE, DONE.
  - LOAD: in_ready=1. On in_valid, register the encoded word into mem_wdata and record in_last, then go to WRITE.
  - WRITE: in_ready=0 and mem_we=1 for exactly one cycle. Next state:
    - DONE if last was recorded or mem_addr==DEPTH-1.
    - Otherwise LOAD with mem_addr+1.
  - DONE: done=1, cpu_hold=0, in_ready=0, and in_valid is ignored.
- Latency and throughput: mem_we is asserted the cycle after acceptance; peak throughput is one word per 2 cycles.
- restart:
  - In DONE: go to LOAD with mem_addr=0 and both error flags cleared.
  - In LOAD or WRITE: ignored.
- Formats by sel (bits[1:0] of every word = 11, bits[6:2] = sel):
  - R (01100): uses funct7b5.
  - I (00000, 00100, 11001):
    - For sel=00100 with funct3 = 001 or 101, the word carries shamt=imm[4:0] and funct7b5.
    - For all other I-type, bits[31:20] = imm[11:0].
  - S (01000).
  - B (11000).
  - U (01101, 00101).
  - J (11011).
- Immediate checks (each failure sets err_imm; the word is still written with truncated bits):
  - I/S: imm must lie in [-2048, 2047].
  - B: imm must lie in [-4096, 4094] and imm[0]=0.
  - J: imm must lie in ±2^20 and imm[0]=0.
  - U: imm[11:0] must be 0.
- Any other sel: write NOP 0x00000013 and set err_unsup.
- Full memory: the write to DEPTH-1 forces DONE even without in_last.

Optional Feature:
- Macro: RV32_ENC_CHECKSUM_EN.
- When defined:
  - Adds output checksum[31:0].
  - checksum is the 32-bit wrap-around sum of every word written since reset/restart.
  - It updates in the WRITE cycle and is cleared by rst or restart.
- When undefined: no port and no adder.

Decomposition:
- Package rv32_pkg holds:
  - selector constants (SEL_LOAD, SEL_OPIMM, SEL_STORE, SEL_BRANCH, SEL_LUI, SEL_AUIPC, SEL_JAL, SEL_JALR, SEL_OP);
  - format enum (FMT_R/I/S/B/U/J);
  - loader state enum;
  - RV32_NOP = 32'h00000013.
- One combinational sub-module, rv32_imm_pack: takes format and imm, returns the scattered immediate bits and the range-error flag.
- All sequencing stays in the top module.

Test Plan:
- addi x1,x0,5 (sel=00100, f3=000, rd=1, imm=5) -> one cycle after accept: mem_we=1, mem_addr=0, mem_wdata=0x00500093.
- Next request sw x2,8(x1) (sel=01000, f3=010, rs1=1, rs2=2, imm=8) -> mem_addr=1, mem_wdata=0x0020A423.
- Next request beq x0,x0,-4 (sel=11000, imm=0xFFFFFFFC) -> 0xFE000EE3. Then lui x5 (sel=01101, imm=0x12345000) with in_last=1 -> 0x123452B7, then done=1, cpu_hold=0, in_ready=0.
- sel=11111 -> NOP 0x00000013 written, err_unsup=1 and it stays high. jal imm=3 -> err_imm=1.
- DEPTH=4, 5 back-to-back valid requests, no in_last -> exactly 4 writes (addresses 0..3), done=1, 5th request never accepted. restart -> mem_addr=0, errors cleared, in_ready=1.
- rst asserted during WRITE -> no mem_we that cycle, all outputs at reset values the next cycle. With RV32_ENC_CHECKSUM_EN, after the addi+sw program checksum=0x0070A4B6.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared definitions for the RV32I instruction encoder/loader: opcode[6:2]
// selectors, instruction formats, loader states and the selector decode.
package rv32_pkg;

  localparam logic [4:0] SEL_LOAD   = 5'b00000;
  localparam logic [4:0] SEL_OPIMM  = 5'b00100;
  localparam logic [4:0] SEL_AUIPC  = 5'b00101;
  localparam logic [4:0] SEL_STORE  = 5'b01000;
  localparam logic [4:0] SEL_OP     = 5'b01100;
  localparam logic [4:0] SEL_LUI    = 5'b01101;
  localparam logic [4:0] SEL_BRANCH = 5'b11000;
  localparam logic [4:0] SEL_JALR   = 5'b11001;
  localparam logic [4:0] SEL_JAL    = 5'b11011;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_WRITE,
    ST_DONE
  } ld_state_e;

  typedef struct packed {
    logic ok;
    fmt_e fmt;
  } sel_info_t;

  // Maps an opcode[6:2] selector to its format; ok=0 for anything unsupported.
  function automatic sel_info_t sel_info(input logic [4:0] sel);
    sel_info_t r;
    r.ok  = 1'b1;
    r.fmt = FMT_R;
    case (sel)
      SEL_OP:                       r.fmt = FMT_R;
      SEL_LOAD, SEL_OPIMM, SEL_JALR: r.fmt = FMT_I;
      SEL_STORE:                    r.fmt = FMT_S;
      SEL_BRANCH:                   r.fmt = FMT_B;
      SEL_LUI, SEL_AUIPC:           r.fmt = FMT_U;
      SEL_JAL:                      r.fmt = FMT_J;
      default:                      r.ok  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rv32_imm_pack.sv
// Scatters a signed immediate into its RV32I bit positions for a given format
// and flags values that are out of range or misaligned for that format.
module rv32_imm_pack
  import rv32_pkg::*;
(
  input  fmt_e               fmt,
  input  logic signed [31:0] imm,
  output logic        [31:0] imm_bits,
  output logic               imm_err
);

  always_comb begin
    imm_bits = 32'd0;
    imm_err  = 1'b0;
    case (fmt)
      FMT_I: begin
        imm_bits = {imm[11:0], 20'd0};
        imm_err  = (imm < -32'sd2048) || (imm > 32'sd2047);
      end
      FMT_S: begin
        imm_bits = {imm[11:5], 13'd0, imm[4:0], 7'd0};
        imm_err  = (imm < -32'sd2048) || (imm > 32'sd2047);
      end
      FMT_B: begin
        imm_bits = {imm[12], imm[10:5], 13'd0, imm[4:1], imm[11], 7'd0};
        imm_err  = (imm < -32'sd4096) || (imm > 32'sd4094) || imm[0];
      end
      FMT_U: begin
        imm_bits = {imm[31:12], 12'd0};
        imm_err  = |imm[11:0];
      end
      FMT_J: begin
        imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'd0};
        imm_err  = (imm < -32'sd1048576) || (imm > 32'sd1048574) || imm[0];
      end
      default: begin
        imm_bits = 32'd0;
        imm_err  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rv32_instr_encoder.sv
// RV32I field encoder that loads encoded words into instruction memory from
// address 0 while holding the core. Optional checksum: RV32_ENC_CHECKSUM_EN.
module rv32_instr_encoder
  import rv32_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [4:0]          sel,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic [4:0]          rd,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic signed [31:0]  imm,
  input  logic                restart,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                done,
  output logic                cpu_hold,
  output logic                err_unsup,
  output logic                err_imm
`ifdef RV32_ENC_CHECKSUM_EN
  ,
  output logic [31:0]         checksum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ld_state_e   state, state_nxt;
  sel_info_t   info_p0;
  logic [31:0] imm_bits_p0;
  logic        imm_err_p0;
  logic [31:0] word_p0;
  logic        is_shift_p0;
  logic        last_p1;
  logic        accept;
  logic        at_end;

  rv32_imm_pack u_imm_pack (
    .fmt      (info_p0.fmt),
    .imm      (imm),
    .imm_bits (imm_bits_p0),
    .imm_err  (imm_err_p0)
  );

  // Stage p0: combinational encode of the request fields
  always_comb begin
    info_p0     = sel_info(sel);
    is_shift_p0 = (sel == SEL_OPIMM) && (funct3[1:0] == 2'b01);
    word_p0     = RV32_NOP;
    case (info_p0.fmt)
      FMT_R:
        word_p0 = {1'b0, funct7b5, 5'd0, rs2, rs1, funct3, rd, sel, 2'b11};
      FMT_I:
        if (is_shift_p0)
          word_p0 = {1'b0, funct7b5, 5'd0, imm[4:0], rs1, funct3, rd, sel, 2'b11};
        else
          word_p0 = imm_bits_p0 | {12'd0, rs1, funct3, rd, sel, 2'b11};
      FMT_S, FMT_B:
        word_p0 = imm_bits_p0 | {7'd0, rs2, rs1, funct3, 5'd0, sel, 2'b11};
      default:
        word_p0 = imm_bits_p0 | {20'd0, rd, sel, 2'b11};
    endcase
    if (!info_p0.ok)
      word_p0 = RV32_NOP;
  end

  assign accept = (state == ST_LOAD) && in_valid;
  assign at_end = last_p1 || (mem_addr == LAST_ADDR);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    done      = 1'b0;
    cpu_hold  = 1'b1;
    case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        // a reset landing on the write cycle cancels the strobe
        mem_we    = !rst;
        state_nxt = at_end ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (restart)
          state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // Stage p1: registered word, address sequencing and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_LOAD;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      last_p1   <= 1'b0;
      err_unsup <= 1'b0;
      err_imm   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mem_wdata <= word_p0;
        last_p1   <= in_last;
        err_unsup <= err_unsup | !info_p0.ok;
        err_imm   <= err_imm | (info_p0.ok & imm_err_p0);
      end
      if (state == ST_WRITE && !at_end)
        mem_addr <= mem_addr + 1'b1;
      if (state == ST_DONE && restart) begin
        mem_addr  <= '0;
        err_unsup <= 1'b0;
        err_imm   <= 1'b0;
      end
    end
  end

`ifdef RV32_ENC_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)
      checksum <= 32'd0;
    else if (state == ST_DONE && restart)
      checksum <= 32'd0;
    else if (state == ST_WRITE)
      checksum <= checksum + mem_wdata;
  end
`endif

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Self-checking bench for rv32_instr_encoder: directed program, error flags,
// restart, full-memory stop, randomized programs and reset during a write.
module tb_rv32_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 3;

  typedef struct packed {
    logic [4:0]  sel;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        last;
  } req_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [4:0]        sel;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic [4:0]        rd, rs1, rs2;
  logic signed [31:0] imm;
  logic              restart;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              done, cpu_hold, err_unsup, err_imm;
`ifdef RV32_ENC_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  logic [ADDR_W-1:0] wq_addr[$];
  logic [31:0]       wq_data[$];

  rv32_instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .sel       (sel),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .restart   (restart),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .done      (done),
    .cpu_hold  (cpu_hold),
    .err_unsup (err_unsup),
    .err_imm   (err_imm)
`ifdef RV32_ENC_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (mem_we === 1'b1) begin
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
    end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1);
  end

  // Reference encoder built from field placement with shifts and masks.
  function automatic logic [31:0] model_word(input req_t r, output logic eimm, output logic eun);
    logic [31:0] w, im;
    int si;
    im   = r.imm;
    si   = $signed(r.imm);
    eimm = 1'b0;
    eun  = 1'b0;
    w    = (32'(r.sel) << 2) | 32'd3;
    case (r.sel)
      5'b01100:
        w = w | (32'(r.f7) << 30) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15)
              | (32'(r.f3) << 12) | (32'(r.rd) << 7);
      5'b00000, 5'b00100, 5'b11001: begin
        w = w | (32'(r.rs1) << 15) | (32'(r.f3) << 12) | (32'(r.rd) << 7);
        if (r.sel == 5'b00100 && (r.f3 == 3'd1 || r.f3 == 3'd5))
          w = w | (32'(r.f7) << 30) | ((im & 32'd31) << 20);
        else
          w = w | ((im & 32'hFFF) << 20);
        eimm = (si < -2048) || (si > 2047);
      end
      5'b01000: begin
        w = w | (((im >> 5) & 32'h7F) << 25) | (32'(r.rs2) << 20) | (32'(r.rs1) << 15)
              | (32'(r.f3) << 12) | ((im & 32'd31) << 7);
        eimm = (si < -2048) || (si > 2047);
      end
      5'b11000: begin
        w = w | (((im >> 12) & 32'd1) << 31) | (((im >> 5) & 32'd63) << 25)
              | (32'(r.rs2) << 20) | (32'(r.rs1) << 15) | (32'(r.f3) << 12)
              | (((im >> 1) & 32'd15) << 8) | (((im >> 11) & 32'd1) << 7);
        eimm = (si < -4096) || (si > 4094) || ((im & 32'd1) != 32'd0);
      end
      5'b01101, 5'b00101: begin
        w = w | (im & 32'hFFFF_F000) | (32'(r.rd) << 7);
        eimm = (im & 32'hFFF) != 32'd0;
      end
      5'b11011: begin
        w = w | (((im >> 20) & 32'd1) << 31) | (((im >> 1) & 32'd1023) << 21)
              | (((im >> 11) & 32'd1) << 20) | (((im >> 12) & 32'd255) << 12)
              | (32'(r.rd) << 7);
        eimm = (si < -1048576) || (si > 1048574) || ((im & 32'd1) != 32'd0);
      end
      default: begin
        w   = 32'h0000_0013;
        eun = 1'b1;
      end
    endcase
    return w;
  endfunction

  function automatic req_t mk(input logic [4:0] s, input logic [2:0] f3, input logic f7,
                              input logic [4:0] rdv, input logic [4:0] r1, input logic [4:0] r2,
                              input logic [31:0] iv, input logic lst);
    req_t r;
    r.sel = s; r.f3 = f3; r.f7 = f7; r.rd = rdv; r.rs1 = r1; r.rs2 = r2; r.imm = iv; r.last = lst;
    return r;
  endfunction

  function automatic req_t rand_req(input logic lst);
    req_t r;
    logic [4:0] sels[11];
    sels = '{5'b00000, 5'b00100, 5'b11001, 5'b01000, 5'b11000, 5'b01101,
             5'b00101, 5'b11011, 5'b01100, 5'b11111, 5'b10101};
    r.sel  = sels[$urandom_range(0, 10)];
    r.f3   = 3'($urandom_range(0, 7));
    r.f7   = 1'($urandom_range(0, 1));
    r.rd   = 5'($urandom_range(0, 31));
    r.rs1  = 5'($urandom_range(0, 31));
    r.rs2  = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 3))
      0:       r.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      1:       r.imm = $urandom;
      2:       r.imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
      default: r.imm = $urandom & 32'hFFFF_F000;
    endcase
    r.last = lst;
    return r;
  endfunction

  task automatic drive(input req_t r);
    sel      = r.sel;
    funct3   = r.f3;
    funct7b5 = r.f7;
    rd       = r.rd;
    rs1      = r.rs1;
    rs2      = r.rs2;
    imm      = r.imm;
    in_last  = r.last;
  endtask

  // Presents one request and returns at the falling edge of its write cycle.
  task automatic send(input req_t r);
    logic ok;
    @(negedge clk);
    drive(r);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_chk++;
    if (!ok) $display("FAIL accept_timeout: in_ready=%b, required 1 within 20 cycles", in_ready);
    else n_pass++;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++; if (mem_we !== 1'b0) $display("FAIL rst_we: got %b, required 0", mem_we); else n_pass++;
    n_chk++; if (mem_addr !== '0) $display("FAIL rst_addr: got %0d, required 0", mem_addr); else n_pass++;
    n_chk++; if (mem_wdata !== 32'd0) $display("FAIL rst_wdata: got %h, required 0", mem_wdata); else n_pass++;
    n_chk++; if ({done, cpu_hold, in_ready} !== 3'b011)
      $display("FAIL rst_ctrl: done/hold/ready got %b, required 011", {done, cpu_hold, in_ready}); else n_pass++;
    n_chk++; if ({err_unsup, err_imm} !== 2'b00)
      $display("FAIL rst_err: got %b, required 00", {err_unsup, err_imm}); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_program();
    req_t p[4];
    logic [31:0] exp_w[4];
    exp_w = '{32'h0050_0093, 32'h0020_A423, 32'hFE00_0EE3, 32'h1234_52B7};
    p[0] = mk(5'b00100, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    p[1] = mk(5'b01000, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    p[2] = mk(5'b11000, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0);
    p[3] = mk(5'b01101, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send(p[i]);
      n_chk++; if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(i) || mem_wdata !== exp_w[i])
        $display("FAIL prog_word%0d: we=%b addr=%0d data=%h, required 1/%0d/%h",
                 i, mem_we, mem_addr, mem_wdata, i, exp_w[i]);
      else n_pass++;
`ifdef RV32_ENC_CHECKSUM_EN
      if (i == 1) begin
        @(negedge clk);
        n_chk++; if (checksum !== 32'h0070_A4B6)
          $display("FAIL prog_checksum: got %h, required 0070a4b6", checksum); else n_pass++;
      end
`endif
    end
    @(negedge clk);
    n_chk++; if ({done, cpu_hold, in_ready, mem_we} !== 4'b1000)
      $display("FAIL prog_done: done/hold/ready/we got %b, required 1000", {done, cpu_hold, in_ready, mem_we});
    else n_pass++;
    n_chk++; if ({err_unsup, err_imm} !== 2'b00)
      $display("FAIL prog_err: got %b, required 00", {err_unsup, err_imm}); else n_pass++;
  endtask

  task automatic test_errors();
    pulse_restart();
    send(mk(5'b11111, 3'b101, 1'b1, 5'd3, 5'd4, 5'd5, 32'd7, 1'b0));
    n_chk++; if (mem_wdata !== 32'h0000_0013)
      $display("FAIL unsup_nop: got %h, required 00000013", mem_wdata); else n_pass++;
    @(negedge clk);
    n_chk++; if (err_unsup !== 1'b1 || err_imm !== 1'b0)
      $display("FAIL unsup_flag: unsup/imm got %b%b, required 10", err_unsup, err_imm); else n_pass++;
    send(mk(5'b11011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b1));
    @(negedge clk);
    n_chk++; if (err_unsup !== 1'b1 || err_imm !== 1'b1 || done !== 1'b1)
      $display("FAIL jal_misalign: unsup/imm/done got %b%b%b, required 111", err_unsup, err_imm, done);
    else n_pass++;
  endtask

  task automatic test_restart();
    pulse_restart();
    n_chk++; if (mem_addr !== '0 || {err_unsup, err_imm} !== 2'b00 || in_ready !== 1'b1 || cpu_hold !== 1'b1)
      $display("FAIL restart_state: addr=%0d err=%b%b ready=%b hold=%b, required 0/00/1/1",
               mem_addr, err_unsup, err_imm, in_ready, cpu_hold);
    else n_pass++;
`ifdef RV32_ENC_CHECKSUM_EN
    n_chk++; if (checksum !== 32'd0) $display("FAIL restart_checksum: got %h, required 0", checksum); else n_pass++;
`endif
    send(mk(5'b00100, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd1, 1'b0));
    pulse_restart();
    send(mk(5'b00100, 3'b000, 1'b0, 5'd3, 5'd0, 5'd0, 32'd2, 1'b1));
    n_chk++; if (mem_addr !== ADDR_W'(1))
      $display("FAIL restart_ignored: addr got %0d, required 1", mem_addr); else n_pass++;
    @(negedge clk);
    n_chk++; if (done !== 1'b1) $display("FAIL last_done: done got %b, required 1", done); else n_pass++;
  endtask

  task automatic test_back_to_back();
    req_t r[5];
    logic [31:0] exp_w;
    logic eimm, eun;
    int idx;
    logic pending;
    logic [31:0] sum;
    for (int i = 0; i < 5; i++) begin
      r[i] = rand_req(1'b0);
      r[i].sel = 5'b01100;
    end
    pulse_restart();
    wq_addr.delete();
    wq_data.delete();
    idx = 0;
    pending = 1'b0;
    drive(r[0]);
    in_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (in_ready === 1'b1 && idx < 5) pending = 1'b1;
      @(negedge clk);
      if (pending) begin
        idx++;
        pending = 1'b0;
        if (idx < 5) drive(r[idx]);
      end
    end
    in_valid = 1'b0;
    n_chk++; if (idx !== 4) $display("FAIL b2b_accepts: got %0d, required 4", idx); else n_pass++;
    n_chk++; if (wq_addr.size() !== 4) $display("FAIL b2b_writes: got %0d, required 4", wq_addr.size()); else n_pass++;
    sum = 32'd0;
    for (int i = 0; i < 4 && i < wq_addr.size(); i++) begin
      exp_w = model_word(r[i], eimm, eun);
      sum = sum + exp_w;
      n_chk++; if (wq_addr[i] !== ADDR_W'(i) || wq_data[i] !== exp_w)
        $display("FAIL b2b_word%0d: addr=%0d data=%h, required %0d/%h", i, wq_addr[i], wq_data[i], i, exp_w);
      else n_pass++;
    end
    n_chk++; if (done !== 1'b1 || in_ready !== 1'b0 || cpu_hold !== 1'b0)
      $display("FAIL b2b_full: done/ready/hold got %b%b%b, required 100", done, in_ready, cpu_hold);
    else n_pass++;
`ifdef RV32_ENC_CHECKSUM_EN
    n_chk++; if (checksum !== sum) $display("FAIL b2b_checksum: got %h, required %h", checksum, sum); else n_pass++;
`endif
  endtask

  task automatic test_random();
    req_t r;
    logic [31:0] exp_w, sum;
    logic eimm, eun, acc_imm, acc_un;
    int n;
    for (int prog = 0; prog < 15; prog++) begin
      pulse_restart();
      n = $urandom_range(1, DEPTH);
      acc_imm = 1'b0;
      acc_un  = 1'b0;
      sum     = 32'd0;
      for (int i = 0; i < n; i++) begin
        r = rand_req(i == n - 1);
        exp_w = model_word(r, eimm, eun);
        acc_imm |= eimm;
        acc_un  |= eun;
        sum = sum + exp_w;
        send(r);
        n_chk++; if (mem_we !== 1'b1 || mem_addr !== ADDR_W'(i) || mem_wdata !== exp_w)
          $display("FAIL rand_word p%0d i%0d sel=%b imm=%h: we=%b addr=%0d data=%h, required 1/%0d/%h",
                   prog, i, r.sel, r.imm, mem_we, mem_addr, mem_wdata, i, exp_w);
        else n_pass++;
      end
      @(negedge clk);
      n_chk++; if (done !== 1'b1 || err_imm !== acc_imm || err_unsup !== acc_un)
        $display("FAIL rand_end p%0d: done/imm/unsup got %b%b%b, required 1%b%b",
                 prog, done, err_imm, err_unsup, acc_imm, acc_un);
      else n_pass++;
`ifdef RV32_ENC_CHECKSUM_EN
      n_chk++; if (checksum !== sum) $display("FAIL rand_checksum p%0d: got %h, required %h", prog, checksum, sum); else n_pass++;
`endif
    end
  endtask

  task automatic test_reset_mid_write();
    pulse_restart();
    send(mk(5'b11011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b0));
    rst = 1'b1;
    #1;
    n_chk++; if (mem_we !== 1'b0) $display("FAIL rst_write_we: got %b, required 0", mem_we); else n_pass++;
    @(negedge clk);
    n_chk++; if (mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== 32'd0 || {done, cpu_hold, in_ready} !== 3'b011
                 || {err_unsup, err_imm} !== 2'b00)
      $display("FAIL rst_write_state: we=%b addr=%0d data=%h dhr=%b err=%b%b, required 0/0/0/011/00",
               mem_we, mem_addr, mem_wdata, {done, cpu_hold, in_ready}, err_unsup, err_imm);
    else n_pass++;
`ifdef RV32_ENC_CHECKSUM_EN
    n_chk++; if (checksum !== 32'd0) $display("FAIL rst_write_checksum: got %h, required 0", checksum); else n_pass++;
`endif
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; restart = 1'b0;
    sel = '0; funct3 = '0; funct7b5 = 1'b0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    test_reset();
    test_program();
    test_errors();
    test_restart();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
